audio_i2s_tx: RTL and testbench
===============================

Name: audio_i2s_tx

Overview:
- Parametrised stereo playback serializer for the audio codec DAC path; successor to the fixed 24-bit single-sample serializer.
- Accepts independent left/right samples through a valid/ready handshake into a small FIFO.
- Serialises MSB-first into configurable-width slots, in I2S or left-justified framing.
- Reports FIFO occupancy and underruns to the sound-generation logic upstream.

Parameters:
- SAMPLE_W, 24, bits per channel sample (8..32).
- SLOT_W, 32, BCLK cycles per channel slot; must be >= SAMPLE_W. Frame = 2*SLOT_W cycles.
- FIFO_DEPTH, 4, stereo sample-pair entries; power of 2, >= 2.
- I2S_MODE, 1: 1 = I2S (MSB one BCLK after LRCK edge); 0 = left-justified (MSB coincident with LRCK edge).

Ports:
- clock12500khz  in  1  bit clock; all logic on posedge.
- resetn  in  1  reset.
- in_left  in  SAMPLE_W  left sample, two's complement.
- in_right  in  SAMPLE_W  right sample.
- in_valid  in  1  sample pair offered.
- in_ready  out  1  FIFO can accept; equals !full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.
- underrun  out  1  one-cycle pulse: frame started with FIFO empty.
- AUD_BCLK  out  1  ~clock12500khz, combinational.
- AUD_DACLRCK  out  1  0 = left slot, 1 = right slot.
- AUD_DACDAT  out  1  serial data.

Behaviour:
- Clocking/reset: reset resetn, asynchronous, active-low; clock clock12500khz.
- All registered outputs change on posedge clock12500khz, i.e. on BCLK falling edge; the codec samples on BCLK rising edge.
- Reset values, applied asynchronously even mid-frame: AUD_DACLRCK=1, AUD_DACDAT=0, underrun=0, FIFO emptied (fifo_level=0, in_ready=1), frame counter=0, state=IDLE, hold register=0.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only at a frame boundary.
  - Simultaneous push and pop: level unchanged.
  - Full: in_ready=0 and in_valid is ignored.
  - No bypass: a pair pushed into an empty FIFO on the boundary cycle does not feed that frame.
- IDLE:
  - Outputs held at reset values.
  - Leaves IDLE when fifo_level != 0. The next cycle is frame cycle 0 (first left slot) and the head pair is popped on the transition.
- RUN:
  - Counter fc counts 0..2*SLOT_W-1 and wraps.
  - AUD_DACLRCK = 0 for fc < SLOT_W, 1 otherwise.
  - Boundary at fc = 2*SLOT_W-1: pop head into shift registers for the next frame. If empty, pulse underrun for that cycle and load the underrun pattern (see Optional Feature).
  - Never returns to IDLE except via reset.
- Data within each slot:
  - I2S_MODE=1: bit k (k=0 for MSB) driven at slot cycle k+1, for k=0..SAMPLE_W-1.
  - I2S_MODE=0: bit k driven at slot cycle k.
  - All other slot cycles drive 0.
  - When SLOT_W==SAMPLE_W and I2S_MODE=1, the LSB occupies cycle 0 of the following slot. This includes right LSB into the next frame's left cycle 0, taken from the previous frame's data.
- Frame rate = 12.5 MHz / (2*SLOT_W); defaults give 195.3125 kHz.

Optional Feature:
- Macro AUD_UNDERRUN_HOLD_EN.
- Defined: on underrun, replay the last successfully popped pair (hold register; 0 if none since reset).
- Undefined: on underrun, transmit zeros in both slots; the hold register is not synthesised.
- underrun pulse identical in both builds.

Test Plan:
- Defaults, push L=0xA5A5A5 R=0x123456 from reset -> IDLE exits. LRCK low for 32 cycles then high 32. DAT at left cycles 1..24 = 0xA5A5A5 MSB-first, cycles 0 and 25..31 = 0. Right cycles 1..24 = 0x123456.
- I2S_MODE=0, SAMPLE_W=SLOT_W=16, push L=0x8001 R=0x7FFE -> left cycle 0 DAT=1, cycle 15 DAT=1, cycles 1..14 = 0. Right cycle 0 DAT=0, cycles 1..14 = 1, cycle 15 = 0. Frame = 32 cycles.
- FIFO_DEPTH=4, hold in_valid=1 while streaming -> in_ready drops when fifo_level=4. Exactly one pop per 64 cycles. Pushed pairs appear in order with no drop or duplicate.
- Push one pair, then stop -> underrun pulses for 1 cycle at fc=63 of the first frame, then again every 64 cycles. With AUD_UNDERRUN_HOLD_EN the last pair repeats; without it DAT=0 throughout.
- Assert resetn=0 at fc=40 with FIFO level 3 -> immediately LRCK=1, DAT=0, fifo_level=0, in_ready=1. After release, stays IDLE until the next push.
- Push and pop on the same cycle (FIFO level 1 at fc=63, in_valid=1) -> level stays 1, no underrun, the new pair plays in the following frame.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// Stereo I2S / left-justified DAC serializer with a sample-pair FIFO and underrun reporting.
// Define AUD_UNDERRUN_HOLD_EN to replay the last popped pair on underrun instead of zeros.
module audio_i2s_tx #(
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned I2S_MODE   = 1
) (
  input  logic                          clock12500khz,
  input  logic                          resetn,
  input  logic [SAMPLE_W-1:0]           in_left,
  input  logic [SAMPLE_W-1:0]           in_right,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          AUD_BCLK,
  output logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = $clog2(2 * SLOT_W);

  localparam logic [FCW-1:0] LastFc   = FCW'(2 * SLOT_W - 1);
  localparam logic [FCW-1:0] SlotFc   = FCW'(SLOT_W);
  localparam logic [FCW-1:0] SampleFc = FCW'(SAMPLE_W);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  // ---------------------------------------------------------------------------
  // Sample-pair FIFO
  // ---------------------------------------------------------------------------
  logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_q, rd_q;
  logic                  push, pop, full, empty;
  logic [SAMPLE_W-1:0]   head_l, head_r;

  assign fifo_level = wr_q - rd_q;
  assign full       = (fifo_level == (AW + 1)'(FIFO_DEPTH));
  assign empty      = (fifo_level == '0);
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign {head_l, head_r} = mem[rd_q[AW-1:0]];

  always_ff @(posedge clock12500khz) begin
    if (push) begin
      mem[wr_q[AW-1:0]] <= {in_left, in_right};
    end
  end

  always_ff @(posedge clock12500khz or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW + 1)'(1);
      if (pop)  rd_q <= rd_q + (AW + 1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Underrun fill pattern
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] ur_l, ur_r;

`ifdef AUD_UNDERRUN_HOLD_EN
  logic [SAMPLE_W-1:0] hold_l_q, hold_r_q;

  always_ff @(posedge clock12500khz or negedge resetn) begin
    if (!resetn) begin
      hold_l_q <= '0;
      hold_r_q <= '0;
    end else if (pop) begin
      hold_l_q <= head_l;
      hold_r_q <= head_r;
    end
  end

  assign ur_l = hold_l_q;
  assign ur_r = hold_r_q;
`else
  assign ur_l = '0;
  assign ur_r = '0;
`endif

  // ---------------------------------------------------------------------------
  // Serial bit selection for a given frame cycle
  // ---------------------------------------------------------------------------
  function automatic logic serial_bit(input logic [FCW-1:0]      fc,
                                      input logic [SAMPLE_W-1:0] l,
                                      input logic [SAMPLE_W-1:0] r,
                                      input logic                prev_lsb);
    logic                right_slot;
    logic [FCW-1:0]      sc;
    logic [SAMPLE_W-1:0] smp;
    right_slot = (fc >= SlotFc);
    sc         = right_slot ? fc - SlotFc : fc;
    smp        = right_slot ? r : l;
    serial_bit = 1'b0;
    if (I2S_MODE != 0) begin
      if (sc == '0) begin
        // Full-width slots: the previous slot's LSB spills into cycle 0.
        if (SLOT_W == SAMPLE_W) serial_bit = right_slot ? l[0] : prev_lsb;
      end else if (sc <= SampleFc) begin
        smp        = smp << (sc - FCW'(1));
        serial_bit = smp[SAMPLE_W-1];
      end
    end else if (sc < SampleFc) begin
      smp        = smp << sc;
      serial_bit = smp[SAMPLE_W-1];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  logic [0:0]          state_q, state_d;
  logic [FCW-1:0]      fc_q, fc_d;
  logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
  logic                prev_lsb_q, prev_lsb_d;
  logic                lrck_q, lrck_d, dat_q, dat_d;
  logic                boundary;

  assign boundary = (state_q == StRun) && (fc_q == LastFc);
  assign underrun = boundary && empty;

  always_comb begin
    state_d    = state_q;
    fc_d       = fc_q;
    left_d     = left_q;
    right_d    = right_q;
    prev_lsb_d = prev_lsb_q;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d    = StRun;
          fc_d       = '0;
          pop        = 1'b1;
          left_d     = head_l;
          right_d    = head_r;
          prev_lsb_d = 1'b0;
        end
      end
      default: begin
        fc_d = boundary ? '0 : fc_q + FCW'(1);
        if (boundary) begin
          prev_lsb_d = right_q[0];
          if (!empty) begin
            pop     = 1'b1;
            left_d  = head_l;
            right_d = head_r;
          end else begin
            left_d  = ur_l;
            right_d = ur_r;
          end
        end
      end
    endcase
    // Outputs are registered from next-state so they move on the BCLK falling edge.
    lrck_d = (state_d == StRun) ? (fc_d >= SlotFc) : 1'b1;
    dat_d  = (state_d == StRun) ? serial_bit(fc_d, left_d, right_d, prev_lsb_d) : 1'b0;
  end

  always_ff @(posedge clock12500khz or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      fc_q       <= '0;
      left_q     <= '0;
      right_q    <= '0;
      prev_lsb_q <= 1'b0;
      lrck_q     <= 1'b1;
      dat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fc_q       <= fc_d;
      left_q     <= left_d;
      right_q    <= right_d;
      prev_lsb_q <= prev_lsb_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
    end
  end

  assign AUD_BCLK    = ~clock12500khz;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dat_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: default I2S 24/32 instance plus a 16/16 left-justified one.
module tb_audio_i2s_tx;

`ifdef AUD_UNDERRUN_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #40 clk = ~clk;

  logic [23:0] d_l, d_r;
  logic        d_v, d_rdy, d_ur, d_bclk, d_lrck, d_dat;
  logic [2:0]  d_lvl;
  logic [15:0] j_l, j_r;
  logic        j_v, j_rdy, j_ur, j_bclk, j_lrck, j_dat;
  logic [2:0]  j_lvl;

  audio_i2s_tx u_dflt (
    .clock12500khz(clk),    .resetn(resetn),
    .in_left(d_l),          .in_right(d_r),        .in_valid(d_v),
    .in_ready(d_rdy),       .fifo_level(d_lvl),    .underrun(d_ur),
    .AUD_BCLK(d_bclk),      .AUD_DACLRCK(d_lrck),  .AUD_DACDAT(d_dat)
  );

  audio_i2s_tx #(.SAMPLE_W(16), .SLOT_W(16), .FIFO_DEPTH(4), .I2S_MODE(0)) u_lj (
    .clock12500khz(clk),    .resetn(resetn),
    .in_left(j_l),          .in_right(j_r),        .in_valid(j_v),
    .in_ready(j_rdy),       .fifo_level(j_lvl),    .underrun(j_ur),
    .AUD_BCLK(j_bclk),      .AUD_DACLRCK(j_lrck),  .AUD_DACDAT(j_dat)
  );

  int total = 0;
  int bad   = 0;
  logic [47:0] dq[$];
  logic [31:0] jq[$];
  int   d_cyc = 0;
  logic d_in  = 1'b0;
  int   j_cyc = 0;
  logic j_in  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Default-instance monitor: rebuild each 64-cycle frame and compare with the queue head.
  initial begin : mon_d
    logic [47:0] cur, last;
    logic [63:0] cd, cl, cu;
    logic        prev, ue;
    cur = '0; last = '0; cd = '0; cl = '0; cu = '0; prev = 1'b1;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        d_in = 1'b0; d_cyc = 0; last = '0; prev = 1'b1;
      end else begin
        if (!d_in && prev && !d_lrck) begin
          d_in = 1'b1; d_cyc = 0;
          chk("dflt frame start queued", 64'(dq.size() != 0), 64'd1);
          if (dq.size() != 0) cur = dq.pop_front();
          else cur = '0;
          last = cur;
        end
        if (d_in) begin
          cd = {cd[62:0], d_dat};
          cl = {cl[62:0], d_lrck};
          cu = {cu[62:0], d_ur};
          if (d_cyc == 63) begin
            ue = (dq.size() == 0);
            chk("dflt dat", cd, {1'b0, cur[47:24], 7'b0, 1'b0, cur[23:0], 7'b0});
            chk("dflt lrck", cl, {32'h0, 32'hFFFF_FFFF});
            chk("dflt underrun", cu, {63'b0, ue});
            if (!ue) begin
              cur = dq.pop_front(); last = cur;
            end else begin
              cur = HoldEn ? last : '0;
            end
            d_cyc = 0;
          end else begin
            d_cyc++;
          end
        end
        prev = d_lrck;
      end
    end
  end

  // Left-justified instance monitor: 32-cycle frames, sample fills its slot exactly.
  initial begin : mon_j
    logic [31:0] cur, last, cd, cl, cu;
    logic        prev, ue;
    cur = '0; last = '0; cd = '0; cl = '0; cu = '0; prev = 1'b1;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        j_in = 1'b0; j_cyc = 0; last = '0; prev = 1'b1;
      end else begin
        if (!j_in && prev && !j_lrck) begin
          j_in = 1'b1; j_cyc = 0;
          chk("lj frame start queued", 64'(jq.size() != 0), 64'd1);
          if (jq.size() != 0) cur = jq.pop_front();
          else cur = '0;
          last = cur;
        end
        if (j_in) begin
          cd = {cd[30:0], j_dat};
          cl = {cl[30:0], j_lrck};
          cu = {cu[30:0], j_ur};
          if (j_cyc == 31) begin
            ue = (jq.size() == 0);
            chk("lj dat", 64'(cd), 64'(cur));
            chk("lj lrck", 64'(cl), 64'h0000_FFFF);
            chk("lj underrun", 64'(cu), 64'(ue));
            if (!ue) begin
              cur = jq.pop_front(); last = cur;
            end else begin
              cur = HoldEn ? last : '0;
            end
            j_cyc = 0;
          end else begin
            j_cyc++;
          end
        end
        prev = j_lrck;
      end
    end
  end

  // Called just after a posedge; the pair is queued once the handshake edge has passed.
  task automatic dpush(input logic [23:0] l, input logic [23:0] r);
    int n = 0;
    d_l = l; d_r = r; d_v = 1'b1;
    while (d_rdy !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) begin
      total++; bad++;
      $display("FAIL dflt push: in_ready got 0 for 1000 cycles, want 1");
    end
    @(posedge clk); #1;
    dq.push_back({l, r});
    d_v = 1'b0;
  endtask

  task automatic jpush(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    j_l = l; j_r = r; j_v = 1'b1;
    while (j_rdy !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) begin
      total++; bad++;
      $display("FAIL lj push: in_ready got 0 for 1000 cycles, want 1");
    end
    @(posedge clk); #1;
    jq.push_back({l, r});
    j_v = 1'b0;
  endtask

  // Returns just after the posedge that starts default-instance frame cycle k.
  task automatic wait_dcyc(input int k);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(d_in && d_cyc == k) && n < 2000);
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL wait frame cycle %0d: not reached in 2000 cycles, want reached", k);
    end
  endtask

  initial begin : stim
    logic [23:0] pl [6];
    int cnt;
    pl = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666};
    resetn = 1'b1;
    d_v = 1'b0; d_l = '0; d_r = '0;
    j_v = 1'b0; j_l = '0; j_r = '0;
    #5 resetn = 1'b0;
    #10;
    chk("reset lrck", 64'(d_lrck), 64'd1);
    chk("reset dat", 64'(d_dat), 64'd0);
    chk("reset level", 64'(d_lvl), 64'd0);
    chk("reset ready", 64'(d_rdy), 64'd1);
    chk("reset underrun", 64'(d_ur), 64'd0);
    chk("lj reset lrck", 64'(j_lrck), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle lrck", 64'(d_lrck), 64'd1);

    dpush(24'hA5A5A5, 24'h123456);
    jpush(16'h8001, 16'h7FFE);
    @(negedge clk);
    chk("bclk", 64'(d_bclk), 64'd1);
    @(posedge clk); #1;
    repeat (200) @(posedge clk);
    #1;

    // Push and pop on the same boundary edge.
    wait_dcyc(5);
    dpush(24'hC0FFEE, 24'h0BEEF0);
    wait_dcyc(63);
    dpush(24'hFACADE, 24'h5EED01);
    chk("same-cycle level", 64'(d_lvl), 64'd1);
    repeat (200) @(posedge clk);
    #1;

    // Stream with valid held high until the FIFO fills.
    wait_dcyc(2);
    for (int i = 0; i < 4; i++) dpush(pl[i], ~pl[i]);
    chk("full level", 64'(d_lvl), 64'd4);
    chk("full ready", 64'(d_rdy), 64'd0);
    dpush(pl[4], ~pl[4]);
    dpush(pl[5], ~pl[5]);
    repeat (64 * 8) @(posedge clk);
    #1;

    // Asynchronous reset mid-frame with three pairs queued.
    wait_dcyc(30);
    dpush(24'h0A0A0A, 24'h0B0B0B);
    dpush(24'h0C0C0C, 24'h0D0D0D);
    dpush(24'h0E0E0E, 24'h0F0F0F);
    wait_dcyc(40);
    chk("pre-reset level", 64'(d_lvl), 64'd3);
    resetn = 1'b0;
    #1;
    chk("mid reset lrck", 64'(d_lrck), 64'd1);
    chk("mid reset dat", 64'(d_dat), 64'd0);
    chk("mid reset level", 64'(d_lvl), 64'd0);
    chk("mid reset ready", 64'(d_rdy), 64'd1);
    chk("mid reset underrun", 64'(d_ur), 64'd0);
    dq.delete();
    jq.delete();
    #100 resetn = 1'b1;
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (d_lrck !== 1'b1 || d_dat !== 1'b0 || j_lrck !== 1'b1) cnt++;
    end
    chk("idle after reset", 64'(cnt), 64'd0);

    @(posedge clk); #1;
    dpush(24'h7FFFFF, 24'h800001);
    repeat (64 * 3) @(posedge clk);
    #1;
    chk("dflt drained", 64'(dq.size()), 64'd0);
    chk("lj drained", 64'(jq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
